vote_collector: RTL
===================

# vote_collector

Sequential ballot-collection stage that sits directly upstream of the 4-voter majority/vote-result logic. It opens a voting round on `start` and accepts one ballot bit per voter over a per-voter valid strobe. It closes the round when all four voters have cast or a timeout expires, then presents the final 4-bit ballot vector `a` with a one-cycle `a_valid` pulse. It also counts completed rounds.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles spent in COLLECT; legal range 1..255.
- `CNT_W`, default 8: width of the round counter.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: opens a round; sampled only in IDLE.
- `vote_valid`  in  4: per-voter ballot strobe. Bit 3 = voter A … bit 0 = voter D.
- `vote_val`  in  4: ballot bit per voter, qualified by `vote_valid`.
- `a`  out  4: final ballot vector for the downstream voting logic. Bit 3 = A … bit 0 = D.
- `a_valid`  out  1: one-cycle pulse; `a` is final and new.
- `busy`  out  1: high in COLLECT and DONE.
- `cast`  out  4: voters whose ballot has been accepted in the current or last round.
- `timed_out`  out  1: last round closed by timeout.
- `rounds`  out  CNT_W: completed-round count; saturates at all-ones.

## Operation
- States: IDLE, COLLECT, DONE. Reset state is IDLE.
- **IDLE:** `busy`=0.
  - `start`=1 → COLLECT.
  - On that edge: `cast`←0, internal ballot shadow←0, timer←0.
- **COLLECT:** `busy`=1. Timer increments every cycle.
  - For each i with `vote_valid[i]`=1 and `cast[i]`=0: shadow[i]←`vote_val[i]`, `cast[i]`←1.
  - First vote wins. A repeat strobe from a voter that has already cast is ignored, whatever its value.
  - Exit to DONE when all four are cast, counting votes accepted in the current cycle.
  - Also exit to DONE when timer == `TIMEOUT`-1.
  - If both exit conditions hold in the same cycle, the round is complete, not timed out: `timed_out`=0.
  - On exit:
    - `a` ← shadow, including votes accepted in the exit cycle.
    - Uncast voters read as 0.
    - `timed_out` ← (not all cast).
    - `rounds` increments by 1, saturating.
- **DONE:** lasts exactly one cycle.
  - `a_valid`=1, `busy`=1.
  - Next state is IDLE unconditionally.
- `start` in COLLECT or DONE is ignored.
- `vote_valid` in IDLE or DONE is ignored.
- `a`, `timed_out` and `cast` hold their values until the next round closes or opens, as described above.
- Arithmetic: timer width is ceil(log2(TIMEOUT+1)), minimum 1 bit. `rounds` wraps never: it stops at 2^CNT_W-1.

## Timing
- **Reset values:** state IDLE, `a`=0000, `a_valid`=0, `busy`=0, `cast`=0000, `timed_out`=0, `rounds`=0.
- **Reset mid-round** (any state): all outputs return to their reset values immediately; no `a_valid` is emitted.
- **Latency:** `start` sampled high at edge n gives COLLECT during cycles n+1 onward.
  - Last vote sampled at edge m → DONE in cycle m+1, with `a`/`a_valid` visible in that cycle.
  - Minimum start-to-`a_valid` latency is 2 cycles (all four votes at edge n+1).
- **Timeout:** COLLECT occupies at most `TIMEOUT` cycles. With no completion, `a_valid` asserts at cycle n+TIMEOUT+1.
- **Back-to-back:** the earliest next `start` is accepted in the IDLE cycle following DONE.
- `a_valid` is never high for two consecutive cycles.
- The downstream logic is combinational and has no backpressure.

## Test plan
- **Reset:** assert `rst_n`=0, release → all outputs at reset values; `start` with no votes and TIMEOUT=15 → `a`=0000, `timed_out`=1, `a_valid` exactly 16 cycles after the start edge, `rounds`=1.
- **Full round:** start, then A=1, B=0, C=1, D=1 on separate cycles → `a`=1011, `cast`=1111, `timed_out`=0, single `a_valid` one cycle after D's vote; the same round with all four votes in one cycle gives latency 2.
- **Duplicate vote:** A votes 1, then A votes 0, then B/C/D vote 0 → `a`=1000, duplicate ignored.
- **Partial round:** only A=1 and C=1 cast, TIMEOUT=15 → `a`=1010, `cast`=1010, `timed_out`=1 at cycle n+16; all four votes arriving on the final COLLECT cycle → `timed_out`=0.
- **Start gating:** `start` pulsed during COLLECT and during DONE → no restart, `rounds` advances by 1 only.
- **Counter saturation and mid-round reset:** CNT_W=2, run 5 rounds → `rounds` stays at 3; reset asserted mid-COLLECT → no `a_valid`, all outputs return to reset values, and a new round then completes normally.

Source files
------------

// File: rtl/vote_collector_if.sv
// Ballot collection bus: round control and ballot strobes in, final ballot vector and status out.
interface vote_collector_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [3:0]       vote_valid;
    logic [3:0]       vote_val;
    logic [3:0]       a;
    logic             a_valid;
    logic             busy;
    logic [3:0]       cast;
    logic             timed_out;
    logic [CNT_W-1:0] rounds;

    modport master (
        output start, vote_valid, vote_val,
        input  a, a_valid, busy, cast, timed_out, rounds
    );

    modport slave (
        input  start, vote_valid, vote_val,
        output a, a_valid, busy, cast, timed_out, rounds
    );
endinterface

// File: rtl/vote_collector.sv
// Collects one first-wins ballot bit per voter per round. A round closes when all four
// voters have cast or on timeout; the ballot vector is then presented with a one-cycle pulse.
module vote_collector #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input logic         clk,
    input logic         rst_n,
    vote_collector_if.slave bus
);
    localparam int TW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic [3:0]       shadow_q;
    logic [3:0]       cast_q;
    logic [3:0]       a_q;
    logic             timed_out_q;
    logic [CNT_W-1:0] rounds_q;

    logic [3:0] accept, cast_d, shadow_d;
    logic       all_cast, expired, close;

    // Votes accepted this cycle count toward completion and appear in the closing vector.
    always_comb begin
        accept   = bus.vote_valid & ~cast_q;
        cast_d   = cast_q | accept;
        shadow_d = (shadow_q & ~accept) | (bus.vote_val & accept);
        all_cast = &cast_d;
        expired  = (timer_q == T_LAST);
        close    = (state_q == COLLECT) && (all_cast || expired);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = COLLECT;
            COLLECT: if (all_cast || expired) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.a_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            shadow_q    <= '0;
            cast_q      <= '0;
            a_q         <= '0;
            timed_out_q <= 1'b0;
            rounds_q    <= '0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                timer_q  <= '0;
                shadow_q <= '0;
                cast_q   <= '0;
            end else if (state_q == COLLECT) begin
                timer_q  <= timer_q + TW'(1);
                shadow_q <= shadow_d;
                cast_q   <= cast_d;
            end
            if (close) begin
                a_q         <= shadow_d & cast_d;
                timed_out_q <= ~all_cast;
                if (rounds_q != '1) rounds_q <= rounds_q + CNT_W'(1);
            end
        end
    end

    assign bus.a         = a_q;
    assign bus.cast      = cast_q;
    assign bus.timed_out = timed_out_q;
    assign bus.rounds    = rounds_q;
endmodule
